// File: rtl/epd_timing_monitor.sv
// Receive-side EPD panel timing checker: rebuilds frame/line structure and reports counts and sticky errors per frame.
// Define EPD_MON_WIDTH_CHECK_EN to compile in the XSTL/XLE pulse-width checks that drive err_width.
module epd_timing_monitor #(
  parameter int High     = 825,
  parameter int EXP_SKV  = 829,
  parameter int LINE_T   = 344,
  parameter int XSTL_LOW = 2,
  parameter int XLE_HIGH = 4
) (
  input  logic        clk_25m,
  input  logic        rst,
  input  logic        SPV,
  input  logic        SKV,
  input  logic        XSTL,
  input  logic        XLE,
  output logic        busy,
  output logic        frame_done,
  output logic [11:0] skv_cnt,
  output logic [11:0] xstl_cnt,
  output logic [11:0] xle_cnt,
  output logic [8:0]  line_period,
  output logic        err_period,
  output logic        err_width,
  output logic        err_count
);

  if (XSTL_LOW < 1 || XSTL_LOW > 255 || XLE_HIGH < 1 || XLE_HIGH > 255 ||
      LINE_T < 1 || 2 * LINE_T > 1023 || High > 4095 || EXP_SKV > 4095) begin : g_param_chk
    $error("epd_timing_monitor: parameter out of supported range");
  end

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  function automatic logic [8:0] clip9(input logic [9:0] v);
    return (v > 10'd511) ? 9'd511 : v[8:0];
  endfunction

  typedef enum logic [1:0] {IDLE, ARMED, SCAN, DONE} state_t;

  state_t      state_q, state_d;
  logic        abort_q, abort_now;
  logic        frame_clr, count_en, to_done;
  logic [3:0]  pin_s1, pin_s2;
  logic [9:0]  ivl_cnt, ivl_d;
  logic [11:0] skv_d, xstl_d, xle_d;
  logic [8:0]  lp_d;
  logic        ep_d;
  logic        xstl_open, xstl_open_d, xle_open, xle_open_d;
  logic        spv_rise, spv_fall, skv_rise, xstl_rise, xstl_fall, xle_rise, xle_fall;

  // s1/s2 edge-detect stage, packed as {SPV, SKV, XSTL, XLE}
  assign spv_rise  =  pin_s1[3] & ~pin_s2[3];
  assign spv_fall  = ~pin_s1[3] &  pin_s2[3];
  assign skv_rise  =  pin_s1[2] & ~pin_s2[2];
  assign xstl_rise =  pin_s1[1] & ~pin_s2[1];
  assign xstl_fall = ~pin_s1[1] &  pin_s2[1];
  assign xle_rise  =  pin_s1[0] & ~pin_s2[0];
  assign xle_fall  = ~pin_s1[0] &  pin_s2[0];

  assign busy       = (state_q == ARMED) || (state_q == SCAN);
  assign frame_done = (state_q == DONE);

  always_comb begin
    state_d   = state_q;
    frame_clr = 1'b0;
    count_en  = 1'b0;
    to_done   = 1'b0;
    abort_now = 1'b0;
    case (state_q)
      IDLE: begin
        if (spv_fall) begin
          state_d   = ARMED;
          frame_clr = 1'b1;
        end
      end
      ARMED: begin
        count_en = 1'b1;
        if (spv_rise) state_d = SCAN;
      end
      SCAN: begin
        count_en = 1'b1;
        if (spv_fall) begin
          state_d   = DONE;
          to_done   = 1'b1;
          abort_now = 1'b1;
        end else if (!skv_rise && ivl_cnt >= 10'(2 * LINE_T)) begin
          // an SKV rise in the same cycle as the timeout keeps the frame alive
          state_d = DONE;
          to_done = 1'b1;
        end
      end
      DONE: begin
        if (abort_q) begin
          state_d   = ARMED;
          frame_clr = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    skv_d       = skv_cnt;
    xstl_d      = xstl_cnt;
    xle_d       = xle_cnt;
    ivl_d       = ivl_cnt;
    lp_d        = line_period;
    ep_d        = err_period;
    xstl_open_d = xstl_open;
    xle_open_d  = xle_open;
    if (frame_clr) begin
      skv_d       = '0;
      xstl_d      = '0;
      xle_d       = '0;
      ivl_d       = '0;
      lp_d        = '0;
      ep_d        = 1'b0;
      xstl_open_d = 1'b0;
      xle_open_d  = 1'b0;
    end else if (count_en) begin
      ivl_d = sat_inc10(ivl_cnt);
      if (skv_rise) begin
        skv_d = sat_inc12(skv_cnt);
        ivl_d = 10'd1;
        lp_d  = clip9(ivl_cnt);
        if (skv_cnt != '0 && ivl_cnt != 10'(LINE_T)) ep_d = 1'b1;
      end
      // a pulse is counted only when it both opened and closed inside the frame
      if (xstl_fall) begin
        xstl_open_d = 1'b1;
      end else if (xstl_rise && xstl_open) begin
        xstl_open_d = 1'b0;
        xstl_d      = sat_inc12(xstl_cnt);
      end
      if (xle_rise) begin
        xle_open_d = 1'b1;
      end else if (xle_fall && xle_open) begin
        xle_open_d = 1'b0;
        xle_d      = sat_inc12(xle_cnt);
      end
    end
  end

  // frame counter / status register stage
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      state_q     <= IDLE;
      abort_q     <= 1'b0;
      pin_s1      <= '0;
      pin_s2      <= '0;
      skv_cnt     <= '0;
      xstl_cnt    <= '0;
      xle_cnt     <= '0;
      ivl_cnt     <= '0;
      line_period <= '0;
      err_period  <= 1'b0;
      err_count   <= 1'b0;
      xstl_open   <= 1'b0;
      xle_open    <= 1'b0;
    end else begin
      state_q     <= state_d;
      abort_q     <= abort_now;
      pin_s1      <= {SPV, SKV, XSTL, XLE};
      pin_s2      <= pin_s1;
      skv_cnt     <= skv_d;
      xstl_cnt    <= xstl_d;
      xle_cnt     <= xle_d;
      ivl_cnt     <= ivl_d;
      line_period <= lp_d;
      err_period  <= ep_d;
      xstl_open   <= xstl_open_d;
      xle_open    <= xle_open_d;
      if (frame_clr)
        err_count <= 1'b0;
      else if (to_done)
        err_count <= abort_now | (skv_d != 12'(EXP_SKV)) |
                     (xstl_d != 12'(High)) | (xle_d != 12'(High));
    end
  end

`ifdef EPD_MON_WIDTH_CHECK_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] xstl_w, xstl_w_d, xle_w, xle_w_d;
  logic       ew_d;

  always_comb begin
    xstl_w_d = xstl_w;
    xle_w_d  = xle_w;
    ew_d     = err_width;
    if (frame_clr) begin
      xstl_w_d = '0;
      xle_w_d  = '0;
      ew_d     = 1'b0;
    end else if (count_en) begin
      if (xstl_fall) begin
        xstl_w_d = 8'd1;
      end else if (xstl_open) begin
        if (xstl_rise) begin
          if (xstl_w != 8'(XSTL_LOW)) ew_d = 1'b1;
        end else begin
          xstl_w_d = sat_inc8(xstl_w);
        end
      end
      if (xle_rise) begin
        xle_w_d = 8'd1;
      end else if (xle_open) begin
        if (xle_fall) begin
          if (xle_w != 8'(XLE_HIGH)) ew_d = 1'b1;
        end else begin
          xle_w_d = sat_inc8(xle_w);
        end
      end
    end
  end

  // pulse-width register stage
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      xstl_w    <= '0;
      xle_w     <= '0;
      err_width <= 1'b0;
    end else begin
      xstl_w    <= xstl_w_d;
      xle_w     <= xle_w_d;
      err_width <= ew_d;
    end
  end
`else
  assign err_width = 1'b0;
`endif

endmodule
